// File: rtl/fifo_burst_reader_if.sv
// Handshake bundle between the burst reader, the upstream FIFO read port
// and the downstream valid/ready stream.
interface fifo_burst_reader_if #(
   parameter int DATA_WIDTH = 64
);
   logic                  fifo_read_req;
   logic                  fifo_read_ready;
   logic [DATA_WIDTH-1:0] fifo_read_data;
   logic                  m_valid;
   logic                  m_ready;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_last;

   // Burst reader side: pops the FIFO and sources the stream.
   modport master (
      output fifo_read_req,
      input  fifo_read_ready,
      input  fifo_read_data,
      output m_valid,
      input  m_ready,
      output m_data,
      output m_last
   );

   // Environment side: the FIFO plus the downstream consumer.
   modport slave (
      input  fifo_read_req,
      output fifo_read_ready,
      output fifo_read_data,
      input  m_valid,
      output m_ready,
      input  m_data,
      input  m_last
   );
endinterface

// File: rtl/fifo_burst_reader.sv
// Burst drain stage for read-latency-1 FIFOs. A start command pops exactly
// num_words words and re-presents them as a valid/ready stream with a last
// marker. A 3-entry buffer absorbs the FIFO read latency so the stream can
// run at one word per cycle; pops are throttled on registered occupancy
// only, so m_ready never reaches fifo_read_req combinationally.
module fifo_burst_reader #(
   parameter int DATA_WIDTH  = 64,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [COUNT_WIDTH-1:0] num_words,
   output logic                   busy,
   output logic                   done,
   fifo_burst_reader_if.master    bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam logic [COUNT_WIDTH-1:0] COUNT_ZERO = {COUNT_WIDTH{1'b0}};
   localparam logic [COUNT_WIDTH-1:0] COUNT_ONE  = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

   // Advance a buffer pointer around the 3-entry ring.
   function automatic logic [1:0] ptr_inc(input logic [1:0] ptr);
      logic [1:0] nxt;
      if (ptr == 2'd2) begin
         nxt = 2'd0;
      end else begin
         nxt = ptr + 2'd1;
      end
      return nxt;
   endfunction

   state_t                 state_r;
   state_t                 state_next_s;
   logic [COUNT_WIDTH-1:0] req_left_r;
   logic [COUNT_WIDTH-1:0] req_left_next_s;
   logic                   busy_r;
   logic                   done_r;
   logic                   done_next_s;

   logic                   inflight_r;
   logic                   inflight_last_r;
   logic [1:0]             occ_r;
   logic [1:0]             occ_next_s;
   logic [1:0]             head_r;
   logic [1:0]             tail_r;
   logic [DATA_WIDTH-1:0]  mem_data_r [0:2];
   logic                   mem_last_r [0:2];

   logic [2:0]             fill_s;
   logic                   pop_s;
   logic                   valid_s;
   logic                   xfer_s;
   logic                   head_last_s;
   logic                   last_xfer_s;

   // Words held plus the one in flight must leave room for the next pop.
   assign fill_s      = {1'b0, occ_r} + {2'b00, inflight_r};
   assign pop_s       = (state_r == ST_READ) && (req_left_r != COUNT_ZERO) &&
                        bus.fifo_read_ready && (fill_s < 3'd3);
   assign valid_s     = (occ_r != 2'd0);
   assign xfer_s      = valid_s && bus.m_ready;
   assign head_last_s = mem_last_r[head_r];
   assign last_xfer_s = xfer_s && head_last_s;

   assign bus.fifo_read_req = pop_s;
   assign bus.m_valid       = valid_s;
   assign bus.m_data        = mem_data_r[head_r];
   assign bus.m_last        = valid_s && head_last_s;
   assign busy              = busy_r;
   assign done              = done_r;

   // Next-state logic: command acceptance, pop counting and burst completion.
   always_comb begin
      state_next_s    = state_r;
      req_left_next_s = req_left_r;
      done_next_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               if (num_words != COUNT_ZERO) begin
                  state_next_s    = ST_READ;
                  req_left_next_s = num_words;
               end else begin
                  done_next_s = 1'b1;
               end
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_READ: begin
            if (pop_s) begin
               req_left_next_s = req_left_r - COUNT_ONE;
               if (req_left_r == COUNT_ONE) begin
                  state_next_s = ST_DRAIN;
               end else begin
                  state_next_s = ST_READ;
               end
            end else begin
               state_next_s = ST_READ;
            end
         end
         ST_DRAIN: begin
            if (last_xfer_s) begin
               state_next_s = ST_IDLE;
               done_next_s  = 1'b1;
            end else begin
               state_next_s = ST_DRAIN;
            end
         end
         default: begin
            state_next_s    = ST_IDLE;
            req_left_next_s = COUNT_ZERO;
         end
      endcase
   end

   // Occupancy: a write and a read in the same cycle cancel out.
   always_comb begin
      occ_next_s = occ_r;
      case ({inflight_r, xfer_s})
         2'b10:   occ_next_s = occ_r + 2'd1;
         2'b01:   occ_next_s = occ_r - 2'd1;
         default: occ_next_s = occ_r;
      endcase
   end

   // Control registers: FSM state, remaining pops and status outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         req_left_r <= COUNT_ZERO;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         state_r    <= state_next_s;
         req_left_r <= req_left_next_s;
         busy_r     <= (state_next_s != ST_IDLE);
         done_r     <= done_next_s;
      end
   end

   // Prefetch buffer: capture the word popped last cycle at the tail and
   // retire the head on each stream transfer; reset drops everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         inflight_r      <= 1'b0;
         inflight_last_r <= 1'b0;
         occ_r           <= 2'd0;
         head_r          <= 2'd0;
         tail_r          <= 2'd0;
         for (int i = 0; i < 3; i++) begin
            mem_data_r[i] <= {DATA_WIDTH{1'b0}};
            mem_last_r[i] <= 1'b0;
         end
      end else begin
         inflight_r      <= pop_s;
         inflight_last_r <= pop_s && (req_left_r == COUNT_ONE);
         occ_r           <= occ_next_s;
         if (inflight_r) begin
            mem_data_r[tail_r] <= bus.fifo_read_data;
            mem_last_r[tail_r] <= inflight_last_r;
            tail_r             <= ptr_inc(tail_r);
         end
         if (xfer_s) begin
            head_r <= ptr_inc(head_r);
         end
      end
   end

endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Downstream drain stage for the accelerator's read-latency-1 FIFOs (symmetric and asymmetric width-conversion variants). On a `start` command it pops exactly `num_words` words through the FIFO's req/ready read port and re-presents them as a valid/ready stream with a `last` marker. A 3-entry prefetch buffer absorbs the FIFO's one-cycle read latency so the stream sustains one word per cycle under no backpressure. `done` signals completion back to the controlling sequencer.

## Interface
- `DATA_WIDTH`, 64, width of FIFO read data and stream data; must match the FIFO's read width.
- `COUNT_WIDTH`, 16, width of the burst length; maximum burst is 2^COUNT_WIDTH-1 words.

- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle burst command; sampled only in IDLE.
- `num_words`  in  COUNT_WIDTH  burst length, sampled with `start`.
- `busy`  out  1  high whenever state != IDLE.
- `done`  out  1  one-cycle pulse when a burst completes.
- `fifo_read_req`  out  1  pop request to the FIFO.
- `fifo_read_ready`  in  1  FIFO non-empty; a pop occurs when `fifo_read_req && fifo_read_ready`.
- `fifo_read_data`  in  DATA_WIDTH  popped word, valid the cycle after the pop.
- `m_valid`  out  1  stream word valid.
- `m_ready`  in  1  downstream accepts; transfer when `m_valid && m_ready`.
- `m_data`  out  DATA_WIDTH  stream word.
- `m_last`  out  1  marks the final word of the burst; qualified by `m_valid`.

## Operation
- FSM states: IDLE, READ, DRAIN.
  - IDLE: `start && num_words != 0` -> READ; load `req_left = num_words`.
  - IDLE: `start && num_words == 0` -> stay IDLE, pulse `done` the next cycle, issue no reads.
  - READ: issue pops while `req_left != 0`; each pop decrements `req_left`. When the pop taking `req_left` from 1 to 0 occurs -> DRAIN.
  - DRAIN: no pops. The transfer with `m_last` -> IDLE, `done = 1` the following cycle.
- `start` is ignored while `busy`.
- Pop condition (combinational): `fifo_read_req = (state == READ) && req_left != 0 && fifo_read_ready && (occ + inflight) < 3`.
  - `occ` is registered buffer occupancy (0..3).
  - `inflight` is a registered flag: a pop occurred last cycle.
  - No combinational path from `m_ready` to `fifo_read_req`.
- Each pop is tagged `last = (req_left == 1)`. The tag travels with `inflight`. On the following cycle, `fifo_read_data` and the tag are written into the buffer tail.
- Buffer: 3-entry circular queue of {data, last}.
  - `m_valid = (occ != 0)`.
  - `m_data`/`m_last` come from the head.
  - Simultaneous write and pop leave `occ` unchanged; head and tail pointers wrap 2 -> 0.
- Head data is held stable while `m_valid && !m_ready`.
- The FIFO going empty mid-burst (`fifo_read_ready = 0`) stalls pops. The burst resumes when it goes non-empty, with no word lost or duplicated.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `fifo_read_req` 0, `m_valid` 0, `m_last` 0, `m_data` 0; `occ`, `inflight`, pointers and `req_left` cleared.
- Reset mid-burst discards buffered words and any in-flight word. The data bus is not captured in the cycle after reset.
- `start` at cycle 0 -> `busy` and first possible `fifo_read_req` at cycle 1.
- Pop at cycle c -> data captured at the end of c+1 -> `m_valid` at c+2. Start-to-first-`m_valid` is 3 cycles.
- Throughput is 1 word/cycle with `m_ready` held high and the FIFO non-empty.
- Last transfer at cycle t -> `busy` 0 and `done` 1 at t+1. A new `start` is accepted at t+1.

## Test plan
- **Burst of 4:** FIFO prefilled 0xA0..0xA3, `num_words = 4`, `start` at cycle 0, `m_ready = 1`.
  - `fifo_read_req` high cycles 1-4.
  - `m_valid` cycles 3-6 with 0xA0..0xA3.
  - `m_last` only at cycle 6.
  - `done` at cycle 7; `busy` high cycles 1-6.
- **Backpressure:** `num_words = 8`, `m_ready = 0`.
  - Exactly 3 pops, then `fifo_read_req` stays 0.
  - `m_data` holds 0xA0.
  - Releasing `m_ready` delivers all 8 words in order, with `m_last` on the eighth.
- **FIFO underflow stall:** FIFO holds 2 words, `num_words = 5`.
  - 2 words stream out, then `m_valid` drops.
  - Pushing 3 more words completes the burst in order; `done` pulses once.
- **Zero length:** `num_words = 0` with `start` -> `done` at cycle 1, no `fifo_read_req`, `busy` stays 0.
- **Single word / ignored start:** `num_words = 1` -> first word carries `m_last`. A `start` with `num_words = 9` asserted while `busy` is ignored: total pops 1.
- **Reset mid-burst:** assert `reset` at cycle 4 of a 6-word burst.
  - At cycle 5: all outputs 0, state IDLE.
  - A subsequent `start` streams fresh FIFO contents with no stale words.
